// File: rtl/video_timing_pkg.sv
// Shared raster timing types, default 800x480 panel timing and total-size helpers
// for the display pipeline.
package video_timing_pkg;

   typedef enum logic [1:0] {WAIT_FULL, WAIT_FRAME, RUN} sched_state_e;

   localparam int DEF_HDISP  = 800;
   localparam int DEF_VDISP  = 480;
   localparam int DEF_HFP    = 40;
   localparam int DEF_HPULSE = 48;
   localparam int DEF_HBP    = 40;
   localparam int DEF_VFP    = 13;
   localparam int DEF_VPULSE = 3;
   localparam int DEF_VBP    = 29;

   function automatic int htotal(input int fp, input int pulse, input int bp, input int disp);
      return fp + pulse + bp + disp;
   endfunction

   function automatic int vtotal(input int fp, input int pulse, input int bp, input int disp);
      return fp + pulse + bp + disp;
   endfunction

endpackage

// File: rtl/pixel_fifo_sched_sync2.sv
// Generic two-flop synchronizer for single-bit CDC flags, asynchronous active-high reset.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pixel_fifo_sched.sv
// Pixel-domain display scheduler: raster timing, one-time FIFO fill wait, frame-aligned
// start of FIFO reads, one pop per active pixel with underflow counting.
module pixel_fifo_sched
   import video_timing_pkg::*;
#(
   parameter int HDISP  = DEF_HDISP,
   parameter int VDISP  = DEF_VDISP,
   parameter int HFP    = DEF_HFP,
   parameter int HPULSE = DEF_HPULSE,
   parameter int HBP    = DEF_HBP,
   parameter int VFP    = DEF_VFP,
   parameter int VPULSE = DEF_VPULSE,
   parameter int VBP    = DEF_VBP
) (
   input  logic        pixel_clk,
   input  logic        sys_rst,
   input  logic        fifo_wfull,
   input  logic        fifo_rempty,
   input  logic [31:0] fifo_rdata,
   output logic        fifo_read,
   output logic        hs_n,
   output logic        vs_n,
   output logic        blank_n,
   output logic [23:0] rgb,
   output logic        frame_start,
   output logic [7:0]  underflow_cnt
);

   localparam int HTOTAL = htotal(HFP, HPULSE, HBP, HDISP);
   localparam int VTOTAL = vtotal(VFP, VPULSE, VBP, VDISP);
   localparam int HW     = $clog2(HTOTAL);
   localparam int VW     = $clog2(VTOTAL);

   localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
   localparam logic [HW-1:0] H_SYNC  = HW'(HFP);
   localparam logic [HW-1:0] H_BPOR  = HW'(HFP + HPULSE);
   localparam logic [HW-1:0] H_ACT   = HW'(HFP + HPULSE + HBP);
   localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
   localparam logic [VW-1:0] V_SYNC  = VW'(VFP);
   localparam logic [VW-1:0] V_BPOR  = VW'(VFP + VPULSE);
   localparam logic [VW-1:0] V_ACT   = VW'(VFP + VPULSE + VBP);

   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   sched_state_e  state;
   logic          wfull_s;
   logic          h_last, v_last, active, hs_on, vs_on, pix_run;
   logic          unused_alpha;

   assign unused_alpha = ^fifo_rdata[31:24];

   sync2 u_wfull_sync (
      .clk (pixel_clk),
      .rst (sys_rst),
      .d   (fifo_wfull),
      .q   (wfull_s)
   );

   assign h_last    = (hcnt == H_LAST);
   assign v_last    = (vcnt == V_LAST);
   assign hs_on     = (hcnt >= H_SYNC) && (hcnt < H_BPOR);
   assign vs_on     = (vcnt >= V_SYNC) && (vcnt < V_BPOR);
   assign active    = (hcnt >= H_ACT) && (vcnt >= V_ACT);
   assign pix_run   = (state == RUN) && active;
   assign fifo_read = pix_run && !fifo_rempty;

   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (h_last) begin
         hcnt <= '0;
         vcnt <= v_last ? '0 : vcnt + VW'(1);
      end else begin
         hcnt <= hcnt + HW'(1);
      end
   end

   // Leaving WAIT_FRAME on the last pixel of a frame makes the first pop the first active pixel.
   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= WAIT_FULL;
      end else begin
         case (state)
            WAIT_FULL:  if (wfull_s) state <= WAIT_FRAME;
            WAIT_FRAME: if (h_last && v_last) state <= RUN;
            RUN:        state <= RUN;
            default:    state <= WAIT_FULL;
         endcase
      end
   end

   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hs_n          <= 1'b1;
         vs_n          <= 1'b1;
         blank_n       <= 1'b0;
         rgb           <= '0;
         frame_start   <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         hs_n        <= !hs_on;
         vs_n        <= !vs_on;
         blank_n     <= active;
         rgb         <= fifo_read ? fifo_rdata[23:0] : 24'h0;
         frame_start <= (hcnt == '0) && (vcnt == '0);
         if (pix_run && fifo_rempty && (underflow_cnt != 8'hFF))
            underflow_cnt <= underflow_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_pixel_fifo_sched.sv
// Scoreboard bench for pixel_fifo_sched on a 14x7 raster with randomized FIFO traffic.
module tb_pixel_fifo_sched;
   import video_timing_pkg::*;

   logic        pixel_clk = 1'b0;
   logic        sys_rst;
   logic        fifo_wfull;
   logic        fifo_rempty;
   logic [31:0] fifo_rdata;
   logic        fifo_read;
   logic        hs_n, vs_n, blank_n, frame_start;
   logic [23:0] rgb;
   logic [7:0]  underflow_cnt;

   pixel_fifo_sched #(
      .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
      .VFP(1), .VPULSE(1), .VBP(1)
   ) dut (
      .pixel_clk     (pixel_clk),
      .sys_rst       (sys_rst),
      .fifo_wfull    (fifo_wfull),
      .fifo_rempty   (fifo_rempty),
      .fifo_rdata    (fifo_rdata),
      .fifo_read     (fifo_read),
      .hs_n          (hs_n),
      .vs_n          (vs_n),
      .blank_n       (blank_n),
      .rgb           (rgb),
      .frame_start   (frame_start),
      .underflow_cnt (underflow_cnt)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      logic        rd;
      logic        hs;
      logic        vs;
      logic        bl;
      logic [23:0] rgb;
      logic        fs;
      logic [7:0]  uc;
   } exp_t;

   exp_t expq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: position from elapsed cycles, fill flag seen two cycles late.
   int   t;
   bit   armed, running;
   bit   wh[$];
   exp_t cur;

   function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] r);
      n_cmp++;
      if (a !== r) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, r, $time);
      end
   endfunction

   function automatic void model_reset();
      t       = 0;
      armed   = 1'b0;
      running = 1'b0;
      wh      = {1'b0, 1'b0};
      cur     = '{rd: 1'b0, hs: 1'b1, vs: 1'b1, bl: 1'b0, rgb: 24'h0, fs: 1'b0, uc: 8'h0};
   endfunction

   function automatic void model_step();
      exp_t e;
      int   h, v;
      bit   act, ws, rd;
      if (sys_rst) begin
         model_reset();
         e = cur;
         expq.push_back(e);
         return;
      end
      h   = t % 14;
      v   = (t / 14) % 7;
      act = (h >= 6) && (v >= 3);
      ws  = wh[0];
      rd  = running && act && !fifo_rempty;
      e    = cur;
      e.rd = rd;
      expq.push_back(e);
      cur.hs  = !((h >= 2) && (h < 4));
      cur.vs  = !(v == 1);
      cur.bl  = act;
      cur.rgb = rd ? fifo_rdata[23:0] : 24'h0;
      cur.fs  = (h == 0) && (v == 0);
      if (running && act && fifo_rempty && cur.uc != 8'd255) cur.uc = cur.uc + 8'd1;
      if (!armed && !running && ws) armed = 1'b1;
      else if (armed && h == 13 && v == 6) begin
         armed   = 1'b0;
         running = 1'b1;
      end
      void'(wh.pop_front());
      wh.push_back(fifo_wfull);
      t++;
   endfunction

   task automatic cyc(input bit rst, input bit w, input bit e, input logic [31:0] d);
      @(posedge pixel_clk);
      #2;
      sys_rst     = rst;
      fifo_wfull  = w;
      fifo_rempty = e;
      fifo_rdata  = d;
      model_step();
   endtask

   initial begin
      exp_t x;
      forever begin
         @(negedge pixel_clk);
         if (expq.size() > 0) begin
            x = expq.pop_front();
            chk("fifo_read",     {31'h0, fifo_read},     {31'h0, x.rd});
            chk("hs_n",          {31'h0, hs_n},          {31'h0, x.hs});
            chk("vs_n",          {31'h0, vs_n},          {31'h0, x.vs});
            chk("blank_n",       {31'h0, blank_n},       {31'h0, x.bl});
            chk("rgb",           {8'h0, rgb},            {8'h0, x.rgb});
            chk("frame_start",   {31'h0, frame_start},   {31'h0, x.fs});
            chk("underflow_cnt", {24'h0, underflow_cnt}, {24'h0, x.uc});
         end
      end
   end

   initial begin
      sys_rst     = 1'b1;
      fifo_wfull  = 1'b0;
      fifo_rempty = 1'b0;
      fifo_rdata  = 32'h0;
      model_reset();

      repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0);

      // Free-running raster, FIFO never fills.
      repeat (200) cyc(1'b0, 1'b0, ($urandom_range(0, 3) == 0), $urandom());

      // Fill flag rises mid-frame; full-rate reads with a constant word, then random data.
      repeat (120) cyc(1'b0, 1'b1, 1'b0, 32'hAA123456);
      repeat (200) cyc(1'b0, 1'b1, 1'b0, $urandom());

      // Fill flag drops after start-up; random underflows.
      repeat (150) cyc(1'b0, 1'b0, ($urandom_range(0, 3) == 0), $urandom());

      // Sustained underflow drives the counter into saturation.
      repeat (12 * 98) cyc(1'b0, 1'b0, 1'b1, $urandom());
      @(negedge pixel_clk);
      chk("ucnt_saturated", {24'h0, underflow_cnt}, 32'd255);

      // Mid-line reset while running, then restart through the fill wait.
      repeat (45) cyc(1'b0, 1'b0, 1'b0, $urandom());
      repeat (2) cyc(1'b1, 1'b1, 1'b0, $urandom());
      @(negedge pixel_clk);
      chk("ucnt_after_rst", {24'h0, underflow_cnt}, 32'd0);
      repeat (60) cyc(1'b0, 1'b0, 1'b0, $urandom());
      repeat (250) cyc(1'b0, 1'b1, ($urandom_range(0, 4) == 0), $urandom());

      repeat (2) @(negedge pixel_clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
